// File: rtl/alu.sv
// Packed-lane vector ALU with a single registered result.
// The result is computed combinationally from the current inputs and loaded
// into ALU_out on every rising clk edge (1-cycle latency, no handshake).
// Lanes are numbered from the MSB: lane 0 is the most significant W bits.
// Optional feature macro: ALU_DIVMOD_EN enables per-lane VDIV/VMOD; when it
// is undefined those function codes produce zero and no divider is built.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset, clears ALU_out
//   rA_64bit_val operand A
//   rB_64bit_val operand B (also per-lane shift amounts)
//   R_ins        function code
//   Op_code      primary opcode, ALU active only for 6'b000001
//   WW           lane width select: 00=8, 01=16, 10=32, 11=64
//   ALU_out      registered result
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:63] rA_64bit_val,
  input  logic [0:63] rB_64bit_val,
  input  logic [0:5]  R_ins,
  input  logic [0:5]  Op_code,
  input  logic [0:1]  WW,
  output logic [0:63] ALU_out
);

  localparam logic [5:0] OP_ALU   = 6'b000001;
  localparam logic [5:0] F_VAND   = 6'b000001;
  localparam logic [5:0] F_VOR    = 6'b000010;
  localparam logic [5:0] F_VXOR   = 6'b000011;
  localparam logic [5:0] F_VNOT   = 6'b000100;
  localparam logic [5:0] F_VMOV   = 6'b000101;
  localparam logic [5:0] F_VADD   = 6'b000110;
  localparam logic [5:0] F_VSUB   = 6'b000111;
  localparam logic [5:0] F_VMULEU = 6'b001000;
  localparam logic [5:0] F_VMULOU = 6'b001001;
  localparam logic [5:0] F_VSLL   = 6'b001010;
  localparam logic [5:0] F_VSRL   = 6'b001011;
  localparam logic [5:0] F_VSRA   = 6'b001100;
  localparam logic [5:0] F_VRTTH  = 6'b001101;
`ifdef ALU_DIVMOD_EN
  localparam logic [5:0] F_VDIV   = 6'b001110;
  localparam logic [5:0] F_VMOD   = 6'b001111;
`endif
  localparam logic [5:0] F_VSQEU  = 6'b010000;
  localparam logic [5:0] F_VSQOU  = 6'b010001;
  localparam logic [5:0] F_VSQRT  = 6'b010010;

  logic [63:0] a;
  logic [63:0] b;
  logic [5:0]  fn;
  logic [5:0]  op;
  logic [1:0]  ww;
  logic [63:0] wres [4];
  logic [63:0] nxt_c;

  assign a  = rA_64bit_val;
  assign b  = rB_64bit_val;
  assign fn = R_ins;
  assign op = Op_code;
  assign ww = WW;

  // Digit-by-digit integer square root; upper zero bits fold away per lane width.
  function automatic logic [31:0] isqrt64(input logic [63:0] x);
    logic [63:0] rem;
    logic [63:0] res;
    logic [63:0] bt;
    rem = x;
    res = '0;
    for (int i = 0; i < 32; i++) begin
      bt = 64'd1 << (62 - 2 * i);
      if (rem >= res + bt) begin
        rem = rem - (res + bt);
        res = (res >> 1) + bt;
      end else begin
        res = res >> 1;
      end
    end
    return res[31:0];
  endfunction

  // One lane engine per width; the WW mux picks the active one.
  for (genvar k = 0; k < 4; k++) begin : g_w
    localparam int unsigned W  = 8 << k;
    localparam int unsigned N  = 64 / W;
    localparam int unsigned SW = $clog2(W);

    logic [W-1:0]  la;
    logic [W-1:0]  lb;
    logic [W-1:0]  lr;
    logic [SW-1:0] sh;
    logic [63:0]   lres;
    logic [63:0]   mres;

    // Lane-local ops: no carry, borrow or shift crosses a lane boundary.
    always_comb begin
      lres = '0;
      la   = '0;
      lb   = '0;
      lr   = '0;
      sh   = '0;
      for (int unsigned j = 0; j < N; j++) begin
        la = a[j*W +: W];
        lb = b[j*W +: W];
        sh = lb[SW-1:0];
        lr = '0;
        case (fn)
          F_VADD:  lr = la + lb;
          F_VSUB:  lr = la - lb;
          F_VSLL:  lr = la << sh;
          F_VSRL:  lr = la >> sh;
          F_VSRA:  lr = $unsigned($signed(la) >>> sh);
          F_VRTTH: lr = {la[W/2-1:0], la[W-1:W/2]};
`ifdef ALU_DIVMOD_EN
          F_VDIV:  lr = (lb == '0) ? '0 : la / lb;
          F_VMOD:  lr = (lb == '0) ? '0 : la % lb;
`endif
          F_VSQRT: lr = W'(isqrt64(64'(la)));
          default: lr = '0;
        endcase
        lres[j*W +: W] = lr;
      end
    end

    // Widening multiply/square: even lane is the upper half of each 2W pair.
    if (k < 3) begin : g_pair
      localparam int unsigned W2 = 2 * W;
      logic [W-1:0]  ea;
      logic [W-1:0]  oa;
      logic [W-1:0]  eb;
      logic [W-1:0]  ob;
      logic [W2-1:0] pr;

      always_comb begin
        mres = '0;
        ea   = '0;
        oa   = '0;
        eb   = '0;
        ob   = '0;
        pr   = '0;
        for (int unsigned p = 0; p < N / 2; p++) begin
          ea = a[p*W2 + W +: W];
          oa = a[p*W2 +: W];
          eb = b[p*W2 + W +: W];
          ob = b[p*W2 +: W];
          case (fn)
            F_VMULEU: pr = W2'(ea) * W2'(eb);
            F_VMULOU: pr = W2'(oa) * W2'(ob);
            F_VSQEU:  pr = W2'(ea) * W2'(ea);
            F_VSQOU:  pr = W2'(oa) * W2'(oa);
            default:  pr = '0;
          endcase
          mres[p*W2 +: W2] = pr;
        end
      end
    end else begin : g_nopair
      assign mres = '0;
    end

    assign wres[k] = lres | mres;
  end

  // Next-result select: width-independent ops first, lane engines otherwise.
  always_comb begin
    nxt_c = '0;
    if (op == OP_ALU) begin
      case (fn)
        F_VAND:  nxt_c = a & b;
        F_VOR:   nxt_c = a | b;
        F_VXOR:  nxt_c = a ^ b;
        F_VNOT:  nxt_c = ~a;
        F_VMOV:  nxt_c = a;
        default: nxt_c = wres[ww];
      endcase
    end
  end

  // Result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_out <= '0;
    end else begin
      ALU_out <= nxt_c;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: a driver issues one operation per cycle and
// queues the expected result; a forked monitor pops and compares one cycle
// later. Expected values come from fixed vectors or a lane-level model.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [0:63] rA_64bit_val;
  logic [0:63] rB_64bit_val;
  logic [0:5]  R_ins;
  logic [0:5]  Op_code;
  logic [0:1]  WW;
  logic [0:63] ALU_out;

  int total;
  int bad;
  logic [63:0] exp_q [$];
  string       name_q [$];

  alu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rA_64bit_val (rA_64bit_val),
    .rB_64bit_val (rB_64bit_val),
    .R_ins        (R_ins),
    .Op_code      (Op_code),
    .WW           (WW),
    .ALU_out      (ALU_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  function automatic logic [63:0] isqrt_ref(input logic [63:0] x);
    logic [127:0] lo;
    logic [127:0] hi;
    logic [127:0] mid;
    lo = 0;
    hi = 128'h1_0000_0000;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= {64'd0, x}) lo = mid;
      else hi = mid;
    end
    return lo[63:0];
  endfunction

  // Reference: split operands into lanes numbered from the MSB and apply the rule.
  function automatic logic [63:0] model(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [1:0] ww,
                                        input logic [63:0] a, input logic [63:0] b);
    int unsigned w;
    int unsigned n;
    int unsigned pos;
    int unsigned s;
    logic [63:0] mask;
    logic [63:0] r;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] z;
    w = 8 << ww;
    n = 64 / w;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 1);
    r = 0;
    if (op != 6'd1) return 64'd0;
    case (fn)
      6'd1: return a & b;
      6'd2: return a | b;
      6'd3: return a ^ b;
      6'd4: return ~a;
      6'd5: return a;
      default: ;
    endcase
    for (int i = 0; i < int'(n); i++) begin
      pos = (n - 1 - i) * w;
      x = (a >> pos) & mask;
      y = (b >> pos) & mask;
      s = y % w;
      z = 0;
      case (fn)
        6'd6:  z = (x + y) & mask;
        6'd7:  z = (x - y) & mask;
        6'd10: z = (x << s) & mask;
        6'd11: z = x >> s;
        6'd12: begin
          z = x >> s;
          if (((x >> (w - 1)) & 1) == 1) z = z | (mask & ~(mask >> s));
        end
        6'd13: z = ((x << (w / 2)) | (x >> (w / 2))) & mask;
`ifdef ALU_DIVMOD_EN
        6'd14: z = (y == 0) ? 0 : x / y;
        6'd15: z = (y == 0) ? 0 : x % y;
`endif
        6'd18: z = isqrt_ref(x);
        6'd8, 6'd9, 6'd16, 6'd17: begin
          // Widening ops: the selected lane's product fills its 2W pair.
          if (w < 64 && (i % 2) == ((fn == 6'd9 || fn == 6'd17) ? 1 : 0)) begin
            z = (fn == 6'd8 || fn == 6'd9) ? x * y : x * x;
            r = r | (z << ((n / 2 - 1 - i / 2) * 2 * w));
          end
          z = 0;
        end
        default: z = 0;
      endcase
      r = r | (z << pos);
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: ALU_out=%h expected=%h", nm, got, want);
    end
  endtask

  task automatic monitor();
    logic [63:0] e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, ALU_out, e);
      end
    end
  endtask

  task automatic drive_push(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] ww,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] want, input string nm);
    Op_code = op;
    R_ins = fn;
    WW = ww;
    rA_64bit_val = a;
    rB_64bit_val = b;
    exp_q.push_back(want);
    name_q.push_back(nm);
  endtask

  task automatic vec(input logic [5:0] fn, input logic [1:0] ww,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] want, input string nm);
    @(negedge clk);
    drive_push(6'd1, fn, ww, a, b, want, nm);
  endtask

  task automatic rnd(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] ww,
                     input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    drive_push(op, fn, ww, a, b, model(op, fn, ww, a, b),
               $sformatf("rnd op=%0d fn=%0d ww=%0d", op, fn, ww));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  logic [63:0] div_a;
  logic [63:0] div_z;
  logic [63:0] mod_a;

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    Op_code = 6'd1;
    R_ins = 6'd5;
    WW = 2'd0;
    rA_64bit_val = 64'h1234_5678_9ABC_DEF0;
    rB_64bit_val = 64'h0;
`ifdef ALU_DIVMOD_EN
    div_a = 64'h01000156_00000104;
    div_z = 64'h01000000_00000000;
    mod_a = 64'h00012300_0C080901;
`else
    div_a = 64'h0;
    div_z = 64'h0;
    mod_a = 64'h0;
`endif
    fork monitor(); join_none
    #3;
    check("reset_state", ALU_out, 64'h0);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", ALU_out, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    vec(6'd6, 2'd0, 64'hFFFFFFFF_FFFFFFFF, 64'h1234FFFF_1111FEC1, 64'h1133FEFE_1010FDC0, "vadd_w8");
    vec(6'd6, 2'd3, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111, 64'h00000000_11111110, "vadd_w64");
    vec(6'd7, 2'd1, 64'hFFFFFFFF_FFFFFFFF, 64'hFF000777_FFFF1234, 64'h00FFF888_0000EDCB, "vsub_w16");
    vec(6'd8, 2'd0, 64'hFF000001_FFFFFFFF, 64'hFF020001_CC0F0001, 64'hFE010000_CB340000, "vmuleu_w8");
    vec(6'd8, 2'd3, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'h0, "vmuleu_w64_zero");
    vec(6'd10, 2'd0, 64'hF0E1F2A2_01010101, 64'h00030001_020FF00A, 64'hF008F244_04800104, "vsll_w8");
    vec(6'd12, 2'd0, 64'hF0E1F2A2_01010101, 64'h02020202_02020202, 64'hFCF8FCE8_00000000, "vsra_w8");
    vec(6'd14, 2'd0, 64'hFF123456_78786345, 64'hFFFF3401_FFDE3211, div_a, "vdiv_w8");
    vec(6'd14, 2'd0, 64'hFF123456_78786345, 64'hFF00FF00_FF00FF00, div_z, "vdiv_zero_divisor");
    vec(6'd15, 2'd0, 64'hFF12FF56_78786345, 64'hFF113701_12101211, mod_a, "vmod_w8");
    vec(6'd13, 2'd0, 64'hFF123456_78786345, 64'h0, 64'hFF214365_87873654, "vrtth_w8");
    vec(6'd18, 2'd0, 64'hFF01FFFF_10040001, 64'h0, 64'h0F010F0F_04020001, "vsqrt_w8");
    vec(6'd18, 2'd3, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 64'h00000000_FFFFFFFF, "vsqrt_w64_max");
    vec(6'd16, 2'd2, 64'hFFFFFFFF_00000003, 64'h0, 64'hFFFFFFFE_00000001, "vsqeu_w32");
    vec(6'd63, 2'd0, 64'h1234, 64'h5678, 64'h0, "bad_fn");
    @(negedge clk);
    drive_push(6'd0, 6'd6, 2'd0, 64'hFFFFFFFF_FFFFFFFF, 64'h1234FFFF_1111FEC1, 64'h0, "opcode_off");

    for (int i = 0; i < 600; i++) begin
      logic [5:0] op;
      logic [63:0] ra;
      logic [63:0] rb;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'd1;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rb = rb & 64'h0F0F_0000_00FF_0F0F;
      rnd(op, 6'($urandom_range(0, 20)), 2'($urandom_range(0, 3)), ra, rb);
    end
    wait_drain();

    // Mid-cycle reset must clear ALU_out without waiting for an edge.
    vec(6'd5, 2'd0, 64'hDEAD_BEEF_0BAD_F00D, 64'h0, 64'hDEAD_BEEF_0BAD_F00D, "pre_reset_vmov");
    wait_drain();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", ALU_out, 64'h0);
    @(negedge clk);
    Op_code = 6'd1;
    R_ins = 6'd4;
    rA_64bit_val = 64'h0;
    @(posedge clk);
    #1;
    check("reset_blocks_load", ALU_out, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_push(6'd1, 6'd6, 2'd1, 64'h0001_0002_0003_FFFF, 64'h0001_0001_0001_0001,
               64'h0002_0003_0004_0000, "first_edge_after_reset");
    for (int i = 0; i < 40; i++) begin
      rnd(6'd1, 6'($urandom_range(6, 18)), 2'($urandom_range(0, 3)),
          {$urandom, $urandom}, {$urandom, $urandom});
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed; vectors use [0:N-1] ordering with bit 0 the MSB.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rA_64bit_val  input  64  operand A.
REQ-005 rB_64bit_val  input  64  operand B; also supplies per-lane shift amounts.
REQ-006 R_ins  input  6  function code.
REQ-007 Op_code  input  6  primary opcode; ALU ops enabled only when 6'b000001.
REQ-008 WW  input  2  lane width: 00=8, 01=16, 10=32, 11=64 bits.
REQ-009 ALU_out  output  64  registered result.

Function
REQ-010 The result SHALL be computed combinationally from current inputs and registered into ALU_out on each rising clk edge; latency is exactly 1 cycle, with no handshake and a new operation accepted every cycle.
REQ-011 Lanes SHALL be numbered from the MSB: lane 0 occupies bits [0:W-1]; "even" lanes are 0,2,4,…; "odd" lanes are 1,3,5,….
REQ-012 If Op_code != 000001, or R_ins is not a code below, the next ALU_out SHALL be all zeros.
REQ-013 000001 VAND, 000010 VOR, 000011 VXOR: bitwise A op B; WW ignored.
REQ-014 000100 VNOT: ~A; 000101 VMOV: A; WW ignored.
REQ-015 000110 VADD / 000111 VSUB: per-lane A+B / A-B modulo 2^W; carries and borrows never cross lanes.
REQ-016 001000 VMULEU / 001001 VMULOU: unsigned product of each even/odd W-bit lane pair, written as a 2W-bit result into the 2W-lane containing it; WW=11 yields zero.
REQ-017 010000 VSQEU / 010001 VSQOU: unsigned square of each even/odd W-bit lane of A, written as a 2W-bit result into the containing 2W-lane; WW=11 yields zero.
REQ-018 001010 VSLL, 001011 VSRL, 001100 VSRA: each A lane is shifted left-logical / right-logical / right-arithmetic by the low log2(W) bits of the same B lane.
REQ-019 001101 VRTTH: each lane's two W/2 halves are swapped.
REQ-020 001110 VDIV / 001111 VMOD: per-lane unsigned quotient / remainder of A by B; a zero divisor lane yields a zero result lane.
REQ-021 010010 VSQRT: per-lane unsigned floor(sqrt(A)) at all four widths; B is ignored.

Reset
REQ-022 While rst_n=0, ALU_out SHALL be forced to 64'h0 immediately, independent of clk.
REQ-023 After rst_n is released, the first rising clk edge SHALL load the current computed result.

Configuration
REQ-024 With macro ALU_DIVMOD_EN defined, VDIV and VMOD SHALL be implemented per REQ-020.
REQ-025 Without ALU_DIVMOD_EN, R_ins 001110 and 001111 SHALL produce all zeros, with no divider logic synthesized.

Verification
REQ-026 Assert reset mid-run with ALU_out nonzero -> ALU_out=0 at once, without a clock edge; first edge after release -> registered result.
REQ-027 VADD: WW=00, A=FFFFFFFF_FFFFFFFF, B=1234FFFF_1111FEC1 -> 1133FEFE_1010FDC0; WW=11, same A, B=00000000_11111111 -> 00000000_11111110.
REQ-028 VSUB: WW=01, A=FFFFFFFF_FFFFFFFF, B=FF000777_FFFF1234 -> 00FFF888_0000EDCB; VMULEU WW=00, A=FF000001_FFFFFFFF, B=FF020001_CC0F0001 -> FE010000_CB340000.
REQ-029 VSLL: WW=00, A=F0E1F2A2_01010101, B=00030001_020FF00A -> F008F244_04800104; VSRA WW=00, A=F0E1F2A2_01010101, B=02 in every byte -> FCF8FCE8_00000000.
REQ-030 VDIV: WW=00, A=FF123456_78786345, B=FFFF3401_FFDE3211 -> 01000156_00000104; with B=FF00FF00_FF00FF00 the zero-divisor lanes -> 00; VMOD WW=00, A=FF12FF56_78786345, B=FF113701_12101211 -> 00012300_0C080901.
REQ-031 VRTTH: WW=00, A=FF123456_78786345 -> FF214365_87873654; VSQRT WW=00, A=FF01FFFF_10040001 -> 0F010F0F_04020001; Op_code=000000 with any operands -> 0.
